commit_mem_write_axi_queue: RTL
===============================

// Module: commit_mem_write_axi_queue
// PURPOSE
//  Buffered commit-stage store path to the AXI write channels. Queues retired stores in a DEPTH-entry FIFO,
//  issues AW and W independently, and keeps up to MAX_OUTST writes awaiting B responses.
//  Serialises uncached stores behind all older traffic and reports drain state for fence/sync handling.
// PARAMETERS
//  DEPTH      4  store queue entries; power of two, >=2
//  MAX_OUTST  4  max retired entries awaiting B response, 1..15
//  ID_WIDTH   4  AXI ID width; AWID driven constant 0
// PORTS
//  clk               in   1         clock
//  resetn            in   1         synchronous active-low reset
//  i_wbmem_valid     in   1         store request valid
//  i_wbmem_addr      in   32        store address
//  i_wbmem_strb      in   4         byte strobes
//  i_wbmem_lswidth   in   2         `LSWIDTH_BYTE/`LSWIDTH_HALF/`LSWIDTH_WORD
//  i_wbmem_data      in   32        store data
//  i_wbmem_uncached  in   1         uncached store; driven onto AWUSER
//  o_wbmem_ready     out  1         queue can accept; enqueue = valid & ready
//  o_idle            out  1         queue empty & no outstanding B
//  i_err_clr         in   1         clears o_bresp_err
//  o_bresp_err       out  1         sticky: a B response with BRESP != 2'b00 was received
//  axi_m_aw*         out  -         awid[ID_WIDTH], awaddr[32], awlen[8]=0, awsize[3], awburst[2]=INCR, awuser, awvalid
//  axi_m_awready     in   1
//  axi_m_w*          out  -         wdata[32], wstrb[4], wlast=1, wvalid
//  axi_m_wready      in   1
//  axi_m_bid/bresp/bvalid in ID_WIDTH/2/1; axi_m_bready out 1
// BEHAVIOUR
//  - Reset: all pointers and counters 0; awvalid=wvalid=0; o_wbmem_ready=1; o_idle=1; o_bresp_err=0; bready=1.
//  - Pointers: head, aw_ptr, w_ptr and tail are log2(DEPTH)+1 bits. Full when tail-head==DEPTH. o_wbmem_ready = ~full.
//  - Enqueue writes the entry at tail on the clock edge. Earliest AWVALID/WVALID for that entry is the next cycle.
//  - AW issue: awvalid = (aw_ptr!=tail) & ~stall. Fields come from entry[aw_ptr]. aw_ptr increments on awvalid&awready.
//  - W issue: wvalid = (w_ptr!=tail) & ~stall. Fields come from entry[w_ptr]. w_ptr increments on wvalid&wready.
//    AW and W may each lead the other by any number of entries, up to tail.
//  - Retire: when head!=tail and both aw_ptr and w_ptr are past head, head increments and outst increments.
//    Retire is at most 1 per cycle.
//  - outst decrements on bvalid&bready. Simultaneous retire and B leaves outst unchanged. outst never wraps.
//  - stall = (outst + (aw_ptr-head) >= MAX_OUTST).
//  - Uncached entry at aw_ptr (or w_ptr): that channel holds valid low until aw_ptr==w_ptr==head and outst==0.
//    Only then does it issue. Entries after it wait until its own B returns, i.e. the next entry needs outst==0.
//  - awsize: BYTE->3'b000, HALF->3'b001, WORD/other->3'b010. awaddr, wstrb and wdata pass through unmodified.
//  - Once asserted, awvalid/wvalid stay high with stable payload until their handshake (AXI rule). No cancellation.
//  - o_idle = (head==tail) & (outst==0). bready is constant 1. bid is ignored.
//  - o_bresp_err: set on a B handshake with bresp!=0. Cleared by i_err_clr. If set and clear occur in the same cycle, set wins.
//  - Full with valid asserted: no enqueue, request must be held by the producer. A same-cycle retire does not raise ready until the next cycle.
//  - Reset mid-operation: queue contents and outst are dropped. Late B responses after reset are accepted and ignored; outst saturates at 0.
// TESTING
//  1. Single store: addr=0x1000, data=0xDEADBEEF, strb=0xF, WORD, awready=wready=1.
//     -> AW and W valid on cycle after enqueue, awsize=010. B pulse then gives o_idle=1.
//  2. awready held 0 for 5 cycles, wready=1; enqueue 3 stores.
//     -> W issues all 3 first, then AW issues 3 in order. Retire in order; outst reaches 3.
//  3. DEPTH=4, awready=wready=0; push 5 stores.
//     -> o_wbmem_ready=0 after the 4th. The 5th enqueues only after the first retire.
//  4. MAX_OUTST=2, bvalid never asserted.
//     -> exactly 2 AW and 2 W handshakes. awvalid=0 thereafter until a B arrives.
//  5. Cached, cached, uncached(0x1FC0_0000), cached with B delayed 10 cycles.
//     -> uncached AW only after both B returned. The 4th store's AW only after the uncached B.
//  6. B with bresp=2'b10 -> o_bresp_err=1 until i_err_clr. Reset mid-burst -> all valids 0, o_idle=1 next cycle.

Source files
------------

// File: rtl/commit_mem_write_axi_queue.sv
// Commit-stage store queue feeding the AXI AW/W channels.
// Retired stores are buffered in a DEPTH-entry ring. AW and W drain it
// independently. An entry leaves the ring ("retires") once both of its beats
// have been accepted. It then counts as outstanding until its B response arrives.
// Uncached stores are fenced: they issue only when nothing older is in flight,
// and the next store waits for the uncached store's B response.
//
// Valid/ready contract on every channel: a beat transfers on a cycle where
// valid and ready are both high. Once valid is raised it stays high with a
// stable payload until that transfer. The store request side follows the same
// rule: the producer holds i_wbmem_* while o_wbmem_ready is low.

`ifndef LSWIDTH_BYTE
`define LSWIDTH_BYTE 2'b00
`endif
`ifndef LSWIDTH_HALF
`define LSWIDTH_HALF 2'b01
`endif
`ifndef LSWIDTH_WORD
`define LSWIDTH_WORD 2'b10
`endif

module commit_mem_write_axi_queue #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_wbmem_valid,
  input  logic [31:0]         i_wbmem_addr,
  input  logic [3:0]          i_wbmem_strb,
  input  logic [1:0]          i_wbmem_lswidth,
  input  logic [31:0]         i_wbmem_data,
  input  logic                i_wbmem_uncached,
  output logic                o_wbmem_ready,
  output logic                o_idle,
  input  logic                i_err_clr,
  output logic                o_bresp_err,
  output logic [ID_WIDTH-1:0] axi_m_awid,
  output logic [31:0]         axi_m_awaddr,
  output logic [7:0]          axi_m_awlen,
  output logic [2:0]          axi_m_awsize,
  output logic [1:0]          axi_m_awburst,
  output logic                axi_m_awuser,
  output logic                axi_m_awvalid,
  input  logic                axi_m_awready,
  output logic [31:0]         axi_m_wdata,
  output logic [3:0]          axi_m_wstrb,
  output logic                axi_m_wlast,
  output logic                axi_m_wvalid,
  input  logic                axi_m_wready,
  input  logic [ID_WIDTH-1:0] axi_m_bid,
  input  logic [1:0]          axi_m_bresp,
  input  logic                axi_m_bvalid,
  output logic                axi_m_bready
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0]   ptr_t;
  typedef logic [PW-1:0] idx_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // Ring storage (no reset: only slots between head and tail are ever read)
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  strb_q [DEPTH];
  logic [1:0]  lsw_q  [DEPTH];
  logic        unc_q  [DEPTH];

  // Pointers carry one wrap bit so full and empty are distinguishable
  ptr_t head_q, aw_ptr_q, w_ptr_q, tail_q;
  ptr_t head_d, aw_ptr_d, w_ptr_d, tail_d;
  logic [3:0] outst_q, outst_d;
  logic       last_unc_q, last_unc_d;   // most recently retired entry was uncached
  logic       aw_hold_q, aw_hold_d;     // AW valid shown but not yet accepted
  logic       w_hold_q, w_hold_d;       // W valid shown but not yet accepted
  logic       err_q, err_d;

  idx_t aw_idx, w_idx, head_idx, tail_idx, aw_prev_idx, w_prev_idx;
  ptr_t aw_lead;
  logic [7:0] inflight;
  logic full, enq, stall, retire, b_hs, outst_zero;
  logic aw_pend, w_pend, aw_fence, w_fence, aw_hs, w_hs;
  logic unused_bid;

  // An entry is fenced when it is uncached, or directly follows an uncached one.
  // Away from the head, such an entry simply waits to become the head.
  // At the head, it waits for every outstanding B response to drain.
  function automatic logic fence_hold(input logic at_head, input logic unc_cur,
                                      input logic unc_prev, input logic last_unc,
                                      input logic no_outst);
    if (at_head) fence_hold = (unc_cur | last_unc) & ~no_outst;
    else         fence_hold = unc_cur | unc_prev;
  endfunction

  assign unused_bid  = ^axi_m_bid;
  assign head_idx    = head_q[PW-1:0];
  assign tail_idx    = tail_q[PW-1:0];
  assign aw_idx      = aw_ptr_q[PW-1:0];
  assign w_idx       = w_ptr_q[PW-1:0];
  assign aw_prev_idx = aw_idx - idx_t'(1);
  assign w_prev_idx  = w_idx - idx_t'(1);

  assign full       = (tail_q - head_q) == DEPTH_P;
  assign enq        = i_wbmem_valid & ~full;
  assign outst_zero = (outst_q == 4'd0);

  // Issued-but-unanswered writes include AW beats sent ahead of retirement
  assign aw_lead  = aw_ptr_q - head_q;
  assign inflight = 8'(outst_q) + 8'(aw_lead);
  assign stall    = inflight >= 8'(MAX_OUTST);

  assign aw_pend  = (aw_ptr_q != tail_q);
  assign w_pend   = (w_ptr_q != tail_q);
  assign aw_fence = fence_hold(aw_ptr_q == head_q, unc_q[aw_idx], unc_q[aw_prev_idx],
                               last_unc_q, outst_zero);
  assign w_fence  = fence_hold(w_ptr_q == head_q, unc_q[w_idx], unc_q[w_prev_idx],
                               last_unc_q, outst_zero);

  // The hold flags keep valid up even if stall rises due to the other channel
  assign axi_m_awvalid = (aw_pend & ~stall & ~aw_fence) | aw_hold_q;
  assign axi_m_wvalid  = (w_pend & ~stall & ~w_fence) | w_hold_q;
  assign aw_hs         = axi_m_awvalid & axi_m_awready;
  assign w_hs          = axi_m_wvalid & axi_m_wready;

  assign retire = (head_q != tail_q) & (aw_ptr_q != head_q) & (w_ptr_q != head_q);
  assign b_hs   = axi_m_bvalid & axi_m_bready;

  // Constant AXI fields: single-beat INCR writes, one ID, always accept B
  assign axi_m_awid    = '0;
  assign axi_m_awlen   = 8'd0;
  assign axi_m_awburst = 2'b01;
  assign axi_m_wlast   = 1'b1;
  assign axi_m_bready  = 1'b1;

  assign axi_m_awaddr = addr_q[aw_idx];
  assign axi_m_awuser = unc_q[aw_idx];
  assign axi_m_wdata  = data_q[w_idx];
  assign axi_m_wstrb  = strb_q[w_idx];

  // Access width to AXI size; unknown encodings fall back to a word
  always_comb begin
    axi_m_awsize = 3'b010;
    case (lsw_q[aw_idx])
      `LSWIDTH_BYTE: axi_m_awsize = 3'b000;
      `LSWIDTH_HALF: axi_m_awsize = 3'b001;
      default:       axi_m_awsize = 3'b010;
    endcase
  end

  assign o_wbmem_ready = ~full;
  assign o_idle        = (head_q == tail_q) & outst_zero;
  assign o_bresp_err   = err_q;

  // Next-state for pointers, outstanding count, fence memory and error flag
  always_comb begin
    tail_d     = tail_q;
    aw_ptr_d   = aw_ptr_q;
    w_ptr_d    = w_ptr_q;
    head_d     = head_q;
    outst_d    = outst_q;
    last_unc_d = last_unc_q;
    err_d      = err_q;
    aw_hold_d  = axi_m_awvalid & ~axi_m_awready;
    w_hold_d   = axi_m_wvalid & ~axi_m_wready;
    if (enq)   tail_d   = tail_q + ptr_t'(1);
    if (aw_hs) aw_ptr_d = aw_ptr_q + ptr_t'(1);
    if (w_hs)  w_ptr_d  = w_ptr_q + ptr_t'(1);
    if (retire) begin
      head_d     = head_q + ptr_t'(1);
      last_unc_d = unc_q[head_idx];
    end
    // A B response with nothing outstanding (e.g. after reset) is dropped
    case ({retire, b_hs})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_zero ? outst_q : outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
    if (b_hs && (axi_m_bresp != 2'b00)) err_d = 1'b1;
    else if (i_err_clr)                 err_d = 1'b0;
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      aw_ptr_q   <= '0;
      w_ptr_q    <= '0;
      tail_q     <= '0;
      outst_q    <= '0;
      last_unc_q <= 1'b0;
      aw_hold_q  <= 1'b0;
      w_hold_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      aw_ptr_q   <= aw_ptr_d;
      w_ptr_q    <= w_ptr_d;
      tail_q     <= tail_d;
      outst_q    <= outst_d;
      last_unc_q <= last_unc_d;
      aw_hold_q  <= aw_hold_d;
      w_hold_q   <= w_hold_d;
      err_q      <= err_d;
    end
  end

  // Capture an accepted store into the slot at tail
  always_ff @(posedge clk) begin
    if (resetn && enq) begin
      addr_q[tail_idx] <= i_wbmem_addr;
      data_q[tail_idx] <= i_wbmem_data;
      strb_q[tail_idx] <= i_wbmem_strb;
      lsw_q[tail_idx]  <= i_wbmem_lswidth;
      unc_q[tail_idx]  <= i_wbmem_uncached;
    end
  end

endmodule
